// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the processing-element family:
//   - FSM state encoding (IDLE, RUN, FLUSH, DONE) as legacy-compatible constants
//   - helpers for derived widths (results per word, accumulator width)
//   - signed saturation helper used by the MAC datapath
// -----------------------------------------------------------------------------
package pe_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Number of DATA_W results packed into one WORD_W word.
  function automatic int pack_of(input int word_w, input int data_w);
    return word_w / data_w;
  endfunction

  // Accumulator width large enough that a full window never overflows.
  function automatic int acc_w_of(input int data_w, input int taps);
    return 32'sd2 * data_w + $clog2(taps);
  endfunction

  // Clamp a signed value to the range of a data_w-bit signed number.
  // The caller truncates the 64-bit return to data_w bits.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                input int data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_w - 32'sd1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 32'sd1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// -----------------------------------------------------------------------------
// pe_mac_sat
// Signed multiply-accumulate over one window with saturation of the window
// result and optional ReLU.
//   Optional feature macro: PE_RELU_EN (negative results are forced to 0).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : clear the accumulator (job start)
//   i_en           : accept a product this cycle
//   i_last         : this product is the final tap of the window
//   i_a, i_b       : signed operands (input element, kernel tap)
//   o_result       : saturated (and optionally rectified) value of acc + a*b;
//                    meaningful in the cycle where i_en & i_last are high
// -----------------------------------------------------------------------------
module pe_mac_sat
  import pe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic                     i_last,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_result
);

  logic signed [ACC_W-1:0]    r_acc;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [DATA_W-1:0]   w_sat;

  assign w_prod = i_a * i_b;
  assign w_sum  = r_acc + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign w_sat  = DATA_W'(sat_to({{(64-ACC_W){w_sum[ACC_W-1]}}, w_sum}, DATA_W));

`ifdef PE_RELU_EN
  assign o_result = w_sat[DATA_W-1] ? {DATA_W{1'b0}} : w_sat;
`else
  assign o_result = w_sat;
`endif

  // Accumulator: restarts at zero after the last tap so the next window
  // can begin on the very next beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (i_clr) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (i_en) begin
      if (i_last) begin
        r_acc <= {ACC_W{1'b0}};
      end else begin
        r_acc <= w_sum;
      end
    end
  end

endmodule

// File: rtl/pe_conv_engine.sv
// -----------------------------------------------------------------------------
// pe_conv_engine
// Streaming 1-D convolution engine: a KERNEL_SIZE-tap signed kernel is applied
// to consecutive non-overlapping windows of the input stream; each window
// result is saturated to DATA_W, packed MSB-lane-first into WORD_W words and
// written to an internal OFM memory readable by the host.
//   Optional feature macro: PE_RELU_EN (ReLU on every window result).
//   Assumes WORD_W/DATA_W, KERNEL_SIZE and OFM_DEPTH are powers of two, PACK>=2.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset (aborts a job)
//   i_start          : job start pulse, sampled only when idle
//   i_num_windows    : number of window results for the job
//   i_kern_we/addr/wdata : kernel word write, ignored while busy
//   i_in_valid/i_in_data, o_in_ready : input element stream handshake
//   i_ofm_raddr, o_ofm_rdata : OFM read port, 1-cycle registered
//   o_busy           : job in progress (RUN, FLUSH, DONE)
//   o_done           : one-cycle pulse at job end
//   o_ofm_wcount     : words written in the current/last job
// -----------------------------------------------------------------------------
module pe_conv_engine
  import pe_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int KERNEL_SIZE = 16,
  parameter int WORD_W      = 32,
  parameter int OFM_DEPTH   = 512,
  parameter int ACC_W       = acc_w_of(DATA_W, KERNEL_SIZE)
) (
  input  logic                                                    i_clk,
  input  logic                                                    i_rst_n,
  input  logic                                                    i_start,
  input  logic [$clog2(OFM_DEPTH)+$clog2(WORD_W/DATA_W)-1:0]      i_num_windows,
  input  logic                                                    i_kern_we,
  input  logic [$clog2(KERNEL_SIZE/(WORD_W/DATA_W))-1:0]          i_kern_addr,
  input  logic [WORD_W-1:0]                                       i_kern_wdata,
  input  logic                                                    i_in_valid,
  input  logic [DATA_W-1:0]                                       i_in_data,
  output logic                                                    o_in_ready,
  input  logic [$clog2(OFM_DEPTH)-1:0]                            i_ofm_raddr,
  output logic [WORD_W-1:0]                                       o_ofm_rdata,
  output logic                                                    o_busy,
  output logic                                                    o_done,
  output logic [$clog2(OFM_DEPTH):0]                              o_ofm_wcount
);

  localparam int PACK   = pack_of(WORD_W, DATA_W);
  localparam int ADDR_W = $clog2(OFM_DEPTH);
  localparam int LANE_W = $clog2(PACK);
  localparam int NW_W   = ADDR_W + LANE_W;
  localparam int TAP_W  = $clog2(KERNEL_SIZE);

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_in_ready;
  logic                     r_busy;
  logic                     r_done;
  logic [TAP_W-1:0]         r_tap;
  logic [NW_W-1:0]          r_win_cnt;
  logic [NW_W-1:0]          r_num_win;
  logic [WORD_W-1:0]        r_pack;
  logic [LANE_W-1:0]        r_lane;
  logic                     r_wr_pend;
  logic [ADDR_W-1:0]        r_wr_addr;
  logic [ADDR_W:0]          r_wcount;
  logic [WORD_W-1:0]        r_rdata;
  logic signed [DATA_W-1:0] r_kern [KERNEL_SIZE];
  logic [WORD_W-1:0]        r_mem  [OFM_DEPTH];

  logic                     w_start;
  logic                     w_accept;
  logic                     w_last_tap;
  logic                     w_win_done;
  logic                     w_last_win;
  logic                     w_flush_shift;
  logic                     w_lane_full;
  logic signed [DATA_W-1:0] w_kern_tap;
  logic signed [DATA_W-1:0] w_result;

  assign w_start       = (r_state == ST_IDLE) & i_start;
  assign w_accept      = i_in_valid & r_in_ready;
  assign w_last_tap    = (r_tap == TAP_W'(KERNEL_SIZE - 1));
  assign w_win_done    = w_accept & w_last_tap;
  assign w_last_win    = w_win_done & (r_win_cnt == (r_num_win - NW_W'(1)));
  // Padding lanes of a partial final word are shifted in one per FLUSH cycle.
  assign w_flush_shift = (r_state == ST_FLUSH) & (r_lane != {LANE_W{1'b0}});
  assign w_lane_full   = (r_lane == LANE_W'(PACK - 1));
  assign w_kern_tap    = r_kern[r_tap];

  assign o_in_ready   = r_in_ready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_ofm_wcount = r_wcount;
  assign o_ofm_rdata  = r_rdata;

  pe_mac_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_start),
    .i_en     (w_accept),
    .i_last   (w_last_tap),
    .i_a      ($signed(i_in_data)),
    .i_b      (w_kern_tap),
    .o_result (w_result)
  );

  // Next-state decode of the job sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_num_windows != {NW_W{1'b0}}) begin
            w_next = ST_RUN;
          end else begin
            w_next = ST_DONE;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last_win) begin
          w_next = ST_FLUSH;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Lane 0 means the last word is complete; its write lands on this edge.
        if (r_lane == {LANE_W{1'b0}}) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_FLUSH;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register and status outputs, registered from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == ST_RUN);
      r_busy     <= (w_next != ST_IDLE);
      r_done     <= (w_next == ST_DONE);
    end
  end

  // Tap and window counters; job length is captured with start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tap     <= {TAP_W{1'b0}};
      r_win_cnt <= {NW_W{1'b0}};
      r_num_win <= {NW_W{1'b0}};
    end else if (w_start) begin
      r_tap     <= {TAP_W{1'b0}};
      r_win_cnt <= {NW_W{1'b0}};
      r_num_win <= i_num_windows;
    end else if (w_accept) begin
      if (w_last_tap) begin
        r_tap     <= {TAP_W{1'b0}};
        r_win_cnt <= r_win_cnt + NW_W'(1);
      end else begin
        r_tap     <= r_tap + TAP_W'(1);
      end
    end
  end

  // Pack register: results enter at the LSB lane, so the first result of a
  // word ends up in the MSB lane. A full word raises a write for next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pack    <= {WORD_W{1'b0}};
      r_lane    <= {LANE_W{1'b0}};
      r_wr_pend <= 1'b0;
    end else begin
      r_wr_pend <= (w_win_done | w_flush_shift) & w_lane_full;
      if (w_start) begin
        r_pack <= {WORD_W{1'b0}};
        r_lane <= {LANE_W{1'b0}};
      end else if (w_win_done | w_flush_shift) begin
        r_pack <= {r_pack[WORD_W-DATA_W-1:0],
                   (w_win_done ? w_result : {DATA_W{1'b0}})};
        r_lane <= w_lane_full ? {LANE_W{1'b0}} : (r_lane + LANE_W'(1));
      end
    end
  end

  // OFM write address and word count for the current job.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_addr <= {ADDR_W{1'b0}};
      r_wcount  <= {(ADDR_W+1){1'b0}};
    end else if (w_start) begin
      r_wr_addr <= {ADDR_W{1'b0}};
      r_wcount  <= {(ADDR_W+1){1'b0}};
    end else if (r_wr_pend) begin
      r_wr_addr <= r_wr_addr + ADDR_W'(1);
      r_wcount  <= r_wcount + (ADDR_W+1)'(1);
    end
  end

  // OFM storage write port (not reset).
  always_ff @(posedge i_clk) begin
    if (r_wr_pend) begin
      r_mem[r_wr_addr] <= r_pack;
    end
  end

  // OFM registered read port; a same-address write returns the old word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= {WORD_W{1'b0}};
    end else begin
      r_rdata <= r_mem[i_ofm_raddr];
    end
  end

  // Kernel storage (not reset); frozen while a job is in progress.
  always_ff @(posedge i_clk) begin
    if (i_kern_we && !r_busy) begin
      for (int k = 0; k < PACK; k++) begin
        r_kern[{i_kern_addr, LANE_W'(k)}] <= i_kern_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_pe_conv_engine.sv
module tb_pe_conv_engine;

  localparam int KS = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] num_windows;
  logic        kern_we;
  logic [1:0]  kern_addr;
  logic [31:0] kern_wdata;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [8:0]  ofm_raddr;
  logic [31:0] ofm_rdata;
  logic        busy;
  logic        done;
  logic [9:0]  ofm_wcount;

  int checks = 0;
  int errors = 0;

  logic signed [7:0] tb_kern [KS];
  int                tb_in[$];
  logic [31:0]       exp_q[$];
  int                done_cnt;
  int                done_cyc;
  bit                ready_dropped;

  typedef struct {
    int          kk;      // 0: all ones, 1: tap0=2 others 0
    int          ik;      // 0: 1..16 ramp, 1: all -10, 2: {w+1,0..}
    int          nw;
    int          gap;     // percent of cycles with in_valid low
    int          exp_wc;
    int          n_ofm;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs [5];

  pe_conv_engine dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_num_windows (num_windows),
    .i_kern_we     (kern_we),
    .i_kern_addr   (kern_addr),
    .i_kern_wdata  (kern_wdata),
    .i_in_valid    (in_valid),
    .i_in_data     (in_data),
    .o_in_ready    (in_ready),
    .i_ofm_raddr   (ofm_raddr),
    .o_ofm_rdata   (ofm_rdata),
    .o_busy        (busy),
    .o_done        (done),
    .o_ofm_wcount  (ofm_wcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setup(input int kk, input int ik, input int nw);
    for (int t = 0; t < KS; t++) begin
      if (kk == 0) tb_kern[t] = 8'sd1;
      else         tb_kern[t] = (t == 0) ? 8'sd2 : 8'sd0;
    end
    tb_in.delete();
    for (int w = 0; w < nw; w++) begin
      for (int t = 0; t < KS; t++) begin
        case (ik)
          0:       tb_in.push_back(t + 1);
          1:       tb_in.push_back(-10);
          default: tb_in.push_back((t == 0) ? (w + 1) : 0);
        endcase
      end
    end
  endtask

  task automatic load_kernel();
    for (int a = 0; a < 4; a++) begin
      kern_we    = 1'b1;
      kern_addr  = 2'(a);
      kern_wdata = {tb_kern[a*4+3], tb_kern[a*4+2], tb_kern[a*4+1], tb_kern[a*4]};
      @(negedge clk);
    end
    kern_we = 1'b0;
  endtask

  // Reference: window sums with plain arithmetic, clamp, pack first result in MSB lane.
  task automatic model(input int nw);
    int res[$];
    int s;
    int v;
    logic [31:0] w;
    exp_q.delete();
    for (int win = 0; win < nw; win++) begin
      s = 0;
      for (int t = 0; t < KS; t++) s += tb_in[win*KS + t] * int'(tb_kern[t]);
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
`ifdef PE_RELU_EN
      if (s < 0) s = 0;
`endif
      res.push_back(s);
    end
    for (int j = 0; j < (nw + 3) / 4; j++) begin
      w = 32'd0;
      for (int l = 0; l < 4; l++) begin
        v = (j*4 + l < nw) ? res[j*4 + l] : 0;
        w = w | (32'(v & 255) << (8 * (3 - l)));
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic read_ofm(input int a, output logic [31:0] d);
    ofm_raddr = 9'(a);
    @(negedge clk);
    d = ofm_rdata;
  endtask

  // Runs one job from a negedge; optional reset abort and busy-time disturbance.
  task automatic run_job(input int nw, input int gap, input int abort_after, input bit disturb);
    int idx = 0;
    int cyc = 0;
    int tail = -1;
    int len;
    bit pv = 0;
    bit pr = 0;
    bit seen = 0;
    bit dist_done = 0;
    len = nw * KS;
    done_cnt = 0;
    done_cyc = -1;
    ready_dropped = 0;
    start = 1'b1;
    num_windows = 11'(nw);
    @(negedge clk);
    start = 1'b0;
    forever begin
      if (pv && pr) idx++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (abort_after >= 0 && idx >= abort_after) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        if (done) done_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      if (done_cyc >= 0) begin
        tail++;
        if (tail >= 3) break;
      end
      if (in_ready) seen = 1;
      else if (seen && idx < len) ready_dropped = 1;
      kern_we = 1'b0;
      start = 1'b0;
      if (disturb && !dist_done && idx >= 20) begin
        dist_done = 1;
        kern_we = 1'b1;
        kern_addr = 2'd0;
        kern_wdata = 32'd0;
        start = 1'b1;
        num_windows = 11'd1;
      end
      if (idx < len && $urandom_range(0, 99) >= gap) begin
        in_valid = 1'b1;
        in_data = 8'(tb_in[idx]);
      end else begin
        in_valid = 1'b0;
        in_data = 8'd0;
      end
      pv = in_valid;
      pr = in_ready;
      cyc++;
      if (cyc > 200 + len * 4) begin
        checks++;
        errors++;
        $display("FAIL job_timeout: got no done after %0d cycles expected done", cyc);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    kern_we = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int nw;
    rst_n = 1'b0;
    start = 1'b0;
    num_windows = 11'd0;
    kern_we = 1'b0;
    kern_addr = 2'd0;
    kern_wdata = 32'd0;
    in_valid = 1'b0;
    in_data = 8'd0;
    ofm_raddr = 9'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wcount", 32'(ofm_wcount), 32'd0);
    chk("rst_rdata", ofm_rdata, 32'd0);

    vecs[0] = '{0, 0, 4, 0, 1, 1, 32'h7F7F7F7F, 32'h0};
`ifdef PE_RELU_EN
    vecs[1] = '{0, 1, 1, 0, 1, 1, 32'h00000000, 32'h0};
`else
    vecs[1] = '{0, 1, 1, 0, 1, 1, 32'h80000000, 32'h0};
`endif
    vecs[2] = '{1, 2, 6, 0, 2, 2, 32'h02040608, 32'h0A0C0000};
    vecs[3] = '{1, 2, 6, 50, 2, 2, 32'h02040608, 32'h0A0C0000};
    // num_windows=0 must leave OFM[0] from the previous job untouched
    vecs[4] = '{1, 2, 0, 0, 0, 1, 32'h02040608, 32'h0};

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].nw > 0) begin
        setup(vecs[i].kk, vecs[i].ik, vecs[i].nw);
        load_kernel();
      end
      run_job(vecs[i].nw, vecs[i].gap, -1, 1'b0);
      chk($sformatf("row%0d_done_count", i), 32'(done_cnt), 32'd1);
      chk($sformatf("row%0d_ready_hold", i), 32'(ready_dropped), 32'd0);
      chk($sformatf("row%0d_wcount", i), 32'(ofm_wcount), 32'(vecs[i].exp_wc));
      if (vecs[i].nw == 0)
        chk("row4_done_latency", 32'(done_cyc >= 0 && done_cyc <= 1), 32'd1);
      for (int j = 0; j < vecs[i].n_ofm; j++) begin
        read_ofm(j, d);
        chk($sformatf("row%0d_ofm%0d", i, j), d, (j == 0) ? vecs[i].exp0 : vecs[i].exp1);
      end
    end

    // start and kern_we while busy must be ignored
    setup(0, 0, 4);
    load_kernel();
    run_job(4, 0, -1, 1'b1);
    chk("busy_ign_done", 32'(done_cnt), 32'd1);
    chk("busy_ign_wcount", 32'(ofm_wcount), 32'd1);
    read_ofm(0, d);
    chk("busy_ign_ofm0", d, 32'h7F7F7F7F);

    // reset after 7 beats, then rerun with the retained kernel
    setup(1, 2, 6);
    load_kernel();
    run_job(6, 0, 7, 1'b0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    run_job(6, 0, -1, 1'b0);
    chk("rerun_done", 32'(done_cnt), 32'd1);
    chk("rerun_wcount", 32'(ofm_wcount), 32'd2);
    read_ofm(0, d);
    chk("rerun_ofm0", d, 32'h02040608);
    read_ofm(1, d);
    chk("rerun_ofm1", d, 32'h0A0C0000);

    // randomized jobs against the reference model
    for (int it = 0; it < 5; it++) begin
      nw = int'($urandom_range(1, 9));
      for (int t = 0; t < KS; t++) begin
        if (it < 3) tb_kern[t] = 8'(int'($urandom_range(0, 8)) - 4);
        else        tb_kern[t] = 8'(int'($urandom_range(0, 255)) - 128);
      end
      tb_in.delete();
      for (int b = 0; b < nw * KS; b++) begin
        if (it < 3) tb_in.push_back(int'($urandom_range(0, 16)) - 8);
        else        tb_in.push_back(int'($urandom_range(0, 255)) - 128);
      end
      load_kernel();
      run_job(nw, 30, -1, 1'b0);
      model(nw);
      chk($sformatf("rand%0d_done", it), 32'(done_cnt), 32'd1);
      chk($sformatf("rand%0d_ready_hold", it), 32'(ready_dropped), 32'd0);
      chk($sformatf("rand%0d_wcount", it), 32'(ofm_wcount), 32'(exp_q.size()));
      for (int j = 0; j < exp_q.size(); j++) begin
        read_ofm(j, d);
        chk($sformatf("rand%0d_ofm%0d", it, j), d, exp_q[j]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
